// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu microcode sequencer: opcode fetch, LUT lookup, uop ROM walk and flow-control decode.
// Optional per-flow watchdog enabled by defining DZCPU_UOP_WATCHDOG_EN.
module dzcpu_uop_sequencer #(
  parameter int         UOP_W    = 13,
  parameter logic [4:0] OP_JCB   = 5'd10,
  parameter int         WDOG_MAX = 32
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMop,
  input  logic             iMopValid,
  output logic             oFetchReq,
  output logic [7:0]       oMop,
  input  logic [7:0]       iFlowIdx,
  output logic [7:0]       oCbMop,
  input  logic [7:0]       iCbFlowIdx,
  output logic [7:0]       oUopAddr,
  input  logic [UOP_W-1:0] iUop,
  input  logic             iFlagZ,
  input  logic             iStall,
  output logic             oOpValid,
  output logic [4:0]       oOp,
  output logic [3:0]       oArg,
  output logic             oPcInc,
  output logic             oUpdateFlags,
  output logic             oEof,
  output logic             oFault
);

  typedef enum logic [1:0] {S_FETCH, S_LOOKUP, S_EXEC, S_CBLOOK} state_t;

  state_t     state, state_next;
  logic [7:0] mop, cb_mop, upc;
  logic [3:0] flow;
  logic       dec_valid, dec_inc, dec_fu, dec_eof;
  logic       is_jcb, in_exec, hold, wdog_trip, fire;

  assign flow = iUop[12:9];
  assign oOp  = iUop[8:4];
  assign oArg = iUop[3:0];

  always_comb begin
    dec_valid = 1'b0;
    dec_inc   = 1'b0;
    dec_fu    = 1'b0;
    dec_eof   = 1'b0;
    case (flow)
      4'd0: dec_valid = 1'b1;
      4'd1: begin dec_valid = 1'b1; dec_inc = 1'b1; end
      4'd2: begin dec_valid = 1'b1; dec_eof = 1'b1; end
      4'd3: begin dec_valid = 1'b1; dec_inc = 1'b1; dec_eof = 1'b1; end
      4'd4: begin dec_valid = 1'b1; dec_fu = 1'b1; dec_eof = 1'b1; end
      4'd5: begin dec_valid = 1'b1; dec_inc = 1'b1; dec_fu = 1'b1; dec_eof = 1'b1; end
      4'd6: begin dec_inc = 1'b1; dec_eof = iFlagZ; dec_valid = !iFlagZ; end
      4'd7: begin dec_inc = 1'b1; dec_eof = !iFlagZ; dec_valid = iFlagZ; end
      4'd8: begin dec_valid = 1'b1; dec_fu = 1'b1; end
      4'd9: ;
      default: dec_eof = 1'b1;
    endcase
  end

  // A JCB uop needs the CB byte in the same cycle; without it the uop waits like a stall.
  assign is_jcb  = (iUop[8:4] == OP_JCB) && !dec_eof;
  assign in_exec = (state == S_EXEC);
  assign hold    = iStall || (is_jcb && !iMopValid);

`ifdef DZCPU_UOP_WATCHDOG_EN
  logic [5:0] wdog_cnt;
  logic       fault;

  assign wdog_trip = in_exec && !hold && !dec_eof && (wdog_cnt == 6'(WDOG_MAX));
  assign oFault    = fault;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      wdog_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      if (state == S_LOOKUP)
        wdog_cnt <= '0;
      else if (in_exec && !hold)
        wdog_cnt <= wdog_cnt + 6'd1;
      if (wdog_trip)
        fault <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign oFault    = 1'b0;
`endif

  assign fire = in_exec && !hold && !wdog_trip;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) state <= S_FETCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (iMopValid) state_next = S_LOOKUP;
      S_LOOKUP: state_next = S_EXEC;
      S_CBLOOK: state_next = S_EXEC;
      S_EXEC: begin
        if (in_exec && !hold) begin
          if (wdog_trip || dec_eof) state_next = S_FETCH;
          else if (is_jcb)          state_next = S_CBLOOK;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    oFetchReq    = (state == S_FETCH);
    oOpValid     = fire && dec_valid;
    oPcInc       = fire && dec_inc;
    oUpdateFlags = fire && dec_fu;
    oEof         = fire && dec_eof;
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      mop    <= '0;
      cb_mop <= '0;
      upc    <= '0;
    end else begin
      if (state == S_FETCH && iMopValid) mop <= iMop;
      if (state == S_LOOKUP) upc <= iFlowIdx;
      if (state == S_CBLOOK) upc <= iCbFlowIdx;
      if (fire && !dec_eof) begin
        if (is_jcb) cb_mop <= iMop;
        else        upc    <= upc + 8'd1;
      end
    end
  end

  assign oMop     = mop;
  assign oCbMop   = cb_mop;
  assign oUopAddr = upc;

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Directed bench for dzcpu_uop_sequencer with a small uop ROM model driven from oUopAddr.
module tb_dzcpu_uop_sequencer;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic [7:0]  iMop = '0;
  logic        iMopValid = 1'b0;
  logic        oFetchReq;
  logic [7:0]  oMop;
  logic [7:0]  iFlowIdx = '0;
  logic [7:0]  oCbMop;
  logic [7:0]  iCbFlowIdx = '0;
  logic [7:0]  oUopAddr;
  logic [12:0] iUop;
  logic        iFlagZ = 1'b0;
  logic        iStall = 1'b0;
  logic        oOpValid;
  logic [4:0]  oOp;
  logic [3:0]  oArg;
  logic        oPcInc;
  logic        oUpdateFlags;
  logic        oEof;
  logic        oFault;

  logic [12:0] rom [256];
  logic [3:0]  strb;
  int          checks = 0;
  int          errors = 0;

  assign iUop = rom[oUopAddr];
  assign strb = {oOpValid, oPcInc, oUpdateFlags, oEof};

  always #5 iClock = ~iClock;

  dzcpu_uop_sequencer dut (
    .iClock(iClock), .iReset(iReset), .iMop(iMop), .iMopValid(iMopValid),
    .oFetchReq(oFetchReq), .oMop(oMop), .iFlowIdx(iFlowIdx), .oCbMop(oCbMop),
    .iCbFlowIdx(iCbFlowIdx), .oUopAddr(oUopAddr), .iUop(iUop), .iFlagZ(iFlagZ),
    .iStall(iStall), .oOpValid(oOpValid), .oOp(oOp), .oArg(oArg), .oPcInc(oPcInc),
    .oUpdateFlags(oUpdateFlags), .oEof(oEof), .oFault(oFault)
  );

  function automatic logic [12:0] mk(input logic [3:0] f, input logic [4:0] o, input logic [3:0] a);
    return {f, o, a};
  endfunction

  task automatic tick;
    @(posedge iClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Issue one opcode byte and step through LOOKUP so the first uop is on the ROM bus.
  task automatic start_flow(input logic [7:0] op, input logic [7:0] idx);
    iFlowIdx  = idx;
    iMop      = op;
    iMopValid = 1'b1;
    tick;
    iMopValid = 1'b0;
    tick;
    chk("flow_start_addr", 16'(oUopAddr), 16'(idx));
  endtask

  logic [3:0] jr_strb [6];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[162] = mk(4'd3, 5'd0, 4'd0);
    rom[17]  = mk(4'd1, 5'd1, 4'd0);
    rom[18]  = mk(4'd0, 5'd2, 4'd0);
    rom[19]  = mk(4'd6, 5'd3, 4'd0);
    rom[20]  = mk(4'd0, 5'd2, 4'd0);
    rom[21]  = mk(4'd0, 5'd2, 4'd0);
    rom[22]  = mk(4'd2, 5'd4, 4'd0);
    rom[13]  = mk(4'd0, 5'd1, 4'd0);
    rom[14]  = mk(4'd1, 5'd2, 4'd0);
    rom[15]  = mk(4'd1, 5'd10, 4'd0);
    rom[16]  = mk(4'd4, 5'd6, 4'd1);
    rom[50]  = mk(4'd0, 5'd7, 4'd5);
    rom[51]  = mk(4'd2, 5'd8, 4'd0);
    rom[255] = mk(4'd8, 5'd9, 4'd0);
    rom[0]   = mk(4'd9, 5'd0, 4'd0);
    rom[1]   = mk(4'd12, 5'd0, 4'd0);
    rom[60]  = mk(4'd7, 5'd3, 4'd0);
    rom[61]  = mk(4'd5, 5'd4, 4'd0);

    // Reset
    repeat (3) @(posedge iClock);
    #1;
    chk("rst_held_fetchreq", 16'(oFetchReq), 16'd1);
    iReset = 1'b1;
    tick;
    chk("rst_strobes", 16'(strb), 16'h0);
    chk("rst_fetchreq", 16'(oFetchReq), 16'd1);
    chk("rst_mop", 16'(oMop), 16'h0);
    chk("rst_cbmop", 16'(oCbMop), 16'h0);
    chk("rst_uaddr", 16'(oUopAddr), 16'h0);
    chk("rst_fault", 16'(oFault), 16'h0);
    $display("reset phase done");

    // NOP opcode: single INC_EOF uop two cycles after the fetch
    iFlowIdx = 8'd162; iMop = 8'h00; iMopValid = 1'b1;
    tick;
    iMopValid = 1'b0;
    chk("nop_lookup_fetchreq", 16'(oFetchReq), 16'd0);
    chk("nop_lookup_strobes", 16'(strb), 16'h0);
    tick;
    chk("nop_exec_addr", 16'(oUopAddr), 16'd162);
    chk("nop_exec_strobes", 16'(strb), 16'(4'b1101));
    tick;
    chk("nop_back_fetch", 16'(oFetchReq), 16'd1);
    chk("nop_back_strobes", 16'(strb), 16'h0);
    $display("nop flow done");

    // JRNZ, Z=1: ends at uop 19 without validating it
    iFlagZ = 1'b1;
    start_flow(8'h20, 8'd17);
    chk("jrz1_17", 16'(strb), 16'(4'b1100));
    tick;
    chk("jrz1_addr18", 16'(oUopAddr), 16'd18);
    chk("jrz1_18", 16'(strb), 16'(4'b1000));
    tick;
    chk("jrz1_addr19", 16'(oUopAddr), 16'd19);
    chk("jrz1_19", 16'(strb), 16'(4'b0101));
    tick;
    chk("jrz1_fetch", 16'(oFetchReq), 16'd1);
    chk("jrz1_no20", 16'(oUopAddr), 16'd19);
    chk("jrz1_mop", 16'(oMop), 16'h20);
    $display("jrnz z=1 flow done");

    // JRNZ, Z=0: full 17..22 walk
    iFlagZ = 1'b0;
    jr_strb = '{4'b1100, 4'b1000, 4'b1100, 4'b1000, 4'b1000, 4'b1001};
    start_flow(8'h20, 8'd17);
    for (int k = 0; k < 6; k++) begin
      chk("jrz0_addr", 16'(oUopAddr), 16'(17 + k));
      chk("jrz0_strobes", 16'(strb), 16'(jr_strb[k]));
      tick;
    end
    chk("jrz0_fetch", 16'(oFetchReq), 16'd1);
    $display("jrnz z=0 flow done");

    // CB prefix: JCB waits for the CB byte, then CBLOOK, then the CB flow
    iCbFlowIdx = 8'd16;
    start_flow(8'hCB, 8'd13);
    chk("cb_13", 16'(strb), 16'(4'b1000));
    tick;
    chk("cb_14", 16'(strb), 16'(4'b1100));
    tick;
    chk("cb_15_addr", 16'(oUopAddr), 16'd15);
    chk("cb_15_op", 16'(oOp), 16'd10);
    chk("cb_15_wait_strobes", 16'(strb), 16'h0);
    tick;
    chk("cb_15_held", 16'(oUopAddr), 16'd15);
    chk("cb_15_no_fetchreq", 16'(oFetchReq), 16'd0);
    iMop = 8'h7C; iMopValid = 1'b1;
    #1;
    chk("cb_15_strobes", 16'(strb), 16'(4'b1100));
    tick;
    iMopValid = 1'b0;
    chk("cb_cbmop", 16'(oCbMop), 16'h7C);
    chk("cb_mop_kept", 16'(oMop), 16'hCB);
    chk("cb_cblook_strobes", 16'(strb), 16'h0);
    tick;
    chk("cb_16_addr", 16'(oUopAddr), 16'd16);
    chk("cb_16_strobes", 16'(strb), 16'(4'b1011));
    chk("cb_16_arg", 16'(oArg), 16'd1);
    tick;
    chk("cb_fetch", 16'(oFetchReq), 16'd1);
    $display("cb prefix flow done");

    // Stall at uop 50 for 4 cycles; stall during FETCH/LOOKUP is ignored
    iStall = 1'b1;
    start_flow(8'h3E, 8'd50);
    iMop = 8'hAA; iMopValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("stall_addr", 16'(oUopAddr), 16'd50);
      chk("stall_strobes", 16'(strb), 16'h0);
      tick;
    end
    iStall = 1'b0; iMopValid = 1'b0;
    #1;
    chk("stall_release_50", 16'(strb), 16'(4'b1000));
    chk("stall_release_arg", 16'(oArg), 16'd5);
    tick;
    chk("stall_51_addr", 16'(oUopAddr), 16'd51);
    chk("stall_51_strobes", 16'(strb), 16'(4'b1001));
    chk("stall_mop_kept", 16'(oMop), 16'h3E);
    tick;
    chk("stall_fetch", 16'(oFetchReq), 16'd1);
    $display("stall flow done");

    // uPC wrap FF->00, NOP uop, reserved flow code
    start_flow(8'h11, 8'd255);
    chk("wrap_ff", 16'(strb), 16'(4'b1010));
    tick;
    chk("wrap_addr0", 16'(oUopAddr), 16'd0);
    chk("wrap_nop", 16'(strb), 16'h0);
    tick;
    chk("wrap_addr1", 16'(oUopAddr), 16'd1);
    chk("reserved_strobes", 16'(strb), 16'(4'b0001));
    tick;
    chk("reserved_fetch", 16'(oFetchReq), 16'd1);
    $display("wrap/reserved flow done");

    // INC_EOF_NZ both ways, then INC_EOF_FU
    iFlagZ = 1'b0;
    start_flow(8'h12, 8'd60);
    chk("nz_z0_end", 16'(strb), 16'(4'b0101));
    tick;
    chk("nz_z0_fetch", 16'(oFetchReq), 16'd1);
    iFlagZ = 1'b1;
    start_flow(8'h12, 8'd60);
    chk("nz_z1_cont", 16'(strb), 16'(4'b1100));
    tick;
    chk("inc_eof_fu_addr", 16'(oUopAddr), 16'd61);
    chk("inc_eof_fu", 16'(strb), 16'(4'b1111));
    tick;
    $display("nz flow done");

    // Reset asserted mid-flow
    iFlagZ = 1'b0;
    start_flow(8'h20, 8'd17);
    tick;
    chk("midrst_pre", 16'(strb), 16'(4'b1000));
    iReset = 1'b0;
    #1;
    chk("midrst_strobes", 16'(strb), 16'h0);
    chk("midrst_fetchreq", 16'(oFetchReq), 16'd1);
    chk("midrst_uaddr", 16'(oUopAddr), 16'd0);
    chk("midrst_mop", 16'(oMop), 16'h0);
    tick;
    iReset = 1'b1;
    tick;
    chk("midrst_after_fetch", 16'(oFetchReq), 16'd1);
    chk("midrst_after_strobes", 16'(strb), 16'h0);
    $display("mid-flow reset done");

`ifdef DZCPU_UOP_WATCHDOG_EN
    for (int i = 100; i < 140; i++) rom[i] = mk(4'd0, 5'd1, 4'd0);
    start_flow(8'h01, 8'd100);
    for (int k = 0; k < 32; k++) begin
      chk("wdog_run", 16'(strb), 16'(4'b1000));
      tick;
    end
    chk("wdog_trip_strobes", 16'(strb), 16'h0);
    chk("wdog_trip_addr", 16'(oUopAddr), 16'd132);
    tick;
    chk("wdog_fault", 16'(oFault), 16'd1);
    chk("wdog_fetch", 16'(oFetchReq), 16'd1);
    $display("watchdog flow done");
`else
    chk("no_wdog_fault", 16'(oFault), 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dzcpu_uop_sequencer.md
Name: dzcpu_uop_sequencer

Overview:
Microcode sequencer for the dzcpu core.
- Requests opcode fetches and presents each fetched opcode byte to the opcode→flow-index LUTs.
- Walks the 13-bit uop ROM from the returned flow index until end-of-flow.
- Decodes each uop's flow-control field into PC-increment, flag-update and end-of-flow strobes, and hands the operation/operand fields to the datapath.
- Sits between the memory interface, the ucode LUT/ROM and the datapath.

Parameters:
UOP_W, 13, uop width: [12:9] flow ctl, [8:4] operation, [3:0] operand
OP_JCB, 5'd10, operation code meaning "jump to CB-prefix flow"
WDOG_MAX, 32, uop count limit per flow (used only with the optional feature)

Ports:
iClock  in  1  clock
iReset  in  1  asynchronous reset, active-low
iMop  in  8  memory read data (opcode / CB byte)
iMopValid  in  1  iMop valid this cycle
oFetchReq  out  1  sequencer waiting for an opcode byte
oMop  out  8  latched opcode, drives main LUT iMop
iFlowIdx  in  8  main LUT result
oCbMop  out  8  latched CB byte, drives CB LUT iMop
iCbFlowIdx  in  8  CB LUT result
oUopAddr  out  8  uop ROM address (registered uPC)
iUop  in  13  uop ROM data (combinational from oUopAddr)
iFlagZ  in  1  current Z flag
iStall  in  1  datapath/memory not ready; hold current uop
oOpValid  out  1  oOp/oArg valid for datapath this cycle
oOp  out  5  operation field
oArg  out  4  operand field
oPcInc  out  1  increment PC this cycle
oUpdateFlags  out  1  datapath writes flags from this uop
oEof  out  1  last uop of flow
oFault  out  1  sticky watchdog fault (0 if feature compiled out)

Behaviour:
- Reset (iReset=0, async): state FETCH.
  - oMop, oCbMop, oUopAddr = 0.
  - oOpValid, oPcInc, oUpdateFlags, oEof, oFault = 0.
  - oFetchReq = 1.
- Reset mid-flow aborts the flow immediately; no strobe is emitted after assertion.
- States: FETCH, LOOKUP, EXEC, CBLOOK.
- FETCH:
  - oFetchReq = 1.
  - On iMopValid: oMop <= iMop; go to LOOKUP.
  - iMopValid in any other state is ignored.
- LOOKUP (1 cycle): oUopAddr <= iFlowIdx; go to EXEC.
  - First oOpValid appears 2 cycles after the iMopValid cycle.
- CBLOOK (1 cycle): oUopAddr <= iCbFlowIdx; go to EXEC.
- EXEC: uop = iUop; oOp/oArg = uop[8:4]/uop[3:0].
  - Strobes are combinational from iUop and gated by !iStall.
  - While iStall=1: all strobes 0, oUopAddr held, state held.
- Flow-control decode in EXEC, not stalled. "Advance" means oUopAddr+1, wrapping 8'hFF→8'h00.
  - 0 OP: valid; advance.
  - 1 INC: valid + PcInc; advance.
  - 2 EOF: valid + Eof; go to FETCH.
  - 3 INC_EOF: valid + PcInc + Eof; go to FETCH.
  - 4 EOF_FU: valid + UpdateFlags + Eof; go to FETCH.
  - 5 INC_EOF_FU: valid + PcInc + UpdateFlags + Eof; go to FETCH.
  - 6 INC_EOF_Z:
    - iFlagZ=1: PcInc + Eof, oOpValid=0; go to FETCH.
    - iFlagZ=0: valid + PcInc; advance.
  - 7 INC_EOF_NZ: same as INC_EOF_Z with the condition inverted (iFlagZ=0 ends the flow).
  - 8 UPDATE_FLAGS: valid + UpdateFlags; advance.
  - 9 NOP: no strobes; advance.
  - 10–15 reserved: treated as EOF, with oOpValid=0.
- JCB: if the uop's operation == OP_JCB and the uop does not end the flow:
  - Sequencer requires iMopValid in the same cycle.
  - oCbMop <= iMop; go to CBLOOK.
  - If iMopValid=0, the sequencer behaves as stalled.
  - The flow-control strobes of the JCB uop itself (e.g. PcInc) are still emitted.
- oFetchReq = 1 only in FETCH. FETCH with iMopValid goes directly to LOOKUP; there is no idle cycle beyond LOOKUP.
- iStall in FETCH/LOOKUP/CBLOOK has no effect.

Optional Feature:
DZCPU_UOP_WATCHDOG_EN:
- Defined:
  - A 6-bit counter clears on LOOKUP and increments on each non-stalled EXEC cycle.
  - If it reaches WDOG_MAX without Eof: oFault <= 1 (sticky until reset), all strobes 0 that cycle, go to FETCH.
- Undefined: no counter; oFault tied to 0; flows run unbounded.

Test Plan:
- Reset: iReset=0 for 3 cycles, then release → all outputs 0 except oFetchReq=1; state FETCH.
- NOP flow: iMop=0x00, iFlowIdx=162, ROM[162]=INC_EOF/nop → exactly 2 cycles after iMopValid, oOpValid=oPcInc=oEof=1 for one cycle; next cycle oFetchReq=1.
- JRNZ with iFlagZ=1: iFlowIdx=17 → oUopAddr sequence 17,18,19.
  - At 19: oPcInc=1, oEof=1, oOpValid=0.
  - Uop 20 is never addressed.
- JRNZ with iFlagZ=0 → addresses 17..22, with oOpValid high on every step; oEof only at 22; oPcInc at 17 and 19.
- CB prefix: iFlowIdx=13; at uop 15 (op=OP_JCB) iMop=0x7C, iCbFlowIdx=16 → oCbMop=0x7C, CBLOOK, then uop 16 with oUpdateFlags=1, oEof=1.
- Stall and reset:
  - iStall=1 for 4 cycles at uop 50 → oUopAddr held at 50 and strobes 0; resumes at 51.
  - Watchdog (macro defined), ROM filled with OP: after 32 uops → oFault=1 and return to FETCH.
  - iReset=0 mid-flow → immediate return to FETCH values.
